id_imm_stage: RTL and testbench

//  Decode-stage front end for the RV32I+P core. Accepts fetched instructions over
//  a valid/ready handshake. Decodes the opcode into the ImmGen select (rv32_pkg::ImmSel_t)
//  and drives the immediate generator with inst[31:7]. Registers inst, pc, immediate and

---
 rtl/rv32_pkg.sv | 11 +
 rtl/id_imm_stage_if.sv | 31 +++
 rtl/id_imm_stage.sv | 106 ++++++++++
 tb/tb_id_imm_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: the immediate-format select consumed by ImmGen.
package rv32_pkg;
  typedef enum logic [2:0] {
    Imm_None = 3'd0,
    Imm_I    = 3'd1,
    Imm_S    = 3'd2,
    Imm_B    = 3'd3,
    Imm_U    = 3'd4,
    Imm_J    = 3'd5
  } ImmSel_t;
endpackage

// File: rtl/id_imm_stage_if.sv
// Fetch->decode->execute bus for id_imm_stage, including the ImmGen side channel.
interface id_imm_stage_if #(parameter int XLEN = 32);
  import rv32_pkg::*;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  ImmSel_t         gen_imm_sel;
  logic [24:0]     gen_inst_imm;
  logic [XLEN-1:0] gen_imm;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  ImmSel_t         id_imm_sel;
  logic            id_illegal;

  modport slave (
    input  if_valid, if_inst, if_pc, flush, gen_imm, id_ready,
    output if_ready, gen_imm_sel, gen_inst_imm,
           id_valid, id_inst, id_pc, id_imm, id_imm_sel, id_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, flush, gen_imm, id_ready,
    input  if_ready, gen_imm_sel, gen_inst_imm,
           id_valid, id_inst, id_pc, id_imm, id_imm_sel, id_illegal
  );
endinterface

// File: rtl/id_imm_stage.sv
// Decode front end: opcode -> ImmGen select, then a main+skid register pair
// toward execute so back-pressure never costs a bubble.
module id_imm_stage #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  id_imm_stage_if.slave  bus
);
  import rv32_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    ImmSel_t         sel;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t  state;
  logic    ready_q;
  entry_t  main_q, skid_q, beat;
  ImmSel_t sel;
  logic    illegal;
  logic    acc, out;

  always_comb begin
    sel     = Imm_None;
    illegal = 1'b0;
    case (bus.if_inst[6:0])
      7'b0000011, 7'b0001111, 7'b0010011,
      7'b1100111, 7'b1110011:             sel = Imm_I;
      7'b0100011:                         sel = Imm_S;
      7'b1100011:                         sel = Imm_B;
      7'b0110111, 7'b0010111:             sel = Imm_U;
      7'b1101111:                         sel = Imm_J;
      7'b0110011, 7'b1110111:             sel = Imm_None;
      default:                            illegal = 1'b1;
    endcase
  end

  assign bus.gen_imm_sel  = sel;
  assign bus.gen_inst_imm = bus.if_inst[31:7];

  // Formats without an immediate carry zero regardless of what ImmGen returns.
  always_comb begin
    beat.inst    = bus.if_inst;
    beat.pc      = bus.if_pc;
    beat.imm     = (sel == Imm_None) ? '0 : bus.gen_imm;
    beat.sel     = sel;
    beat.illegal = illegal;
  end

  assign acc = bus.if_valid & ready_q;
  assign out = (state != EMPTY) & bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (bus.flush) begin
      // Data regs keep stale contents; only the occupancy is dropped.
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          main_q <= beat;
          state  <= ONE;
        end
        ONE: begin
          if (acc && out) begin
            main_q <= beat;
          end else if (out) begin
            state <= EMPTY;
          end else if (acc) begin
            skid_q  <= beat;
            state   <= TWO;
            ready_q <= 1'b0;
          end
        end
        TWO: if (out) begin
          main_q  <= skid_q;
          state   <= ONE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.if_ready   = ready_q;
  assign bus.id_valid   = (state != EMPTY);
  assign bus.id_inst    = main_q.inst;
  assign bus.id_pc      = main_q.pc;
  assign bus.id_imm     = main_q.imm;
  assign bus.id_imm_sel = main_q.sel;
  assign bus.id_illegal = main_q.illegal;
endmodule

// File: tb/tb_id_imm_stage.sv
// Directed bench for id_imm_stage: vector table for decode/imm, then
// back-pressure, flush and reset sequences.
module tb_id_imm_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_imm_stage_if #(.XLEN(32)) bus();
  id_imm_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Reference ImmGen; non-immediate formats return junk the stage must zero.
  logic [24:0] x;
  assign x = bus.gen_inst_imm;
  always_comb begin
    case (bus.gen_imm_sel)
      Imm_I:   bus.gen_imm = {{20{x[24]}}, x[24:13]};
      Imm_S:   bus.gen_imm = {{20{x[24]}}, x[24:18], x[4:0]};
      Imm_B:   bus.gen_imm = {{19{x[24]}}, x[24], x[0], x[23:18], x[4:1], 1'b0};
      Imm_U:   bus.gen_imm = {x[24:5], 12'b0};
      Imm_J:   bus.gen_imm = {{11{x[24]}}, x[24], x[12:5], x[13], x[23:14], 1'b0};
      default: bus.gen_imm = 32'hDEADBEEF;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    ImmSel_t     sel;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t tbl[10];
  int   idx, oidx;
  logic acc, outx;

  initial begin
    tbl[0] = '{"addi",  32'hFFF00093, Imm_I,    32'hFFFFFFFF, 1'b0};
    tbl[1] = '{"sw",    32'h00112623, Imm_S,    32'h0000000C, 1'b0};
    tbl[2] = '{"beq",   32'hFE000EE3, Imm_B,    32'hFFFFFFFC, 1'b0};
    tbl[3] = '{"lui",   32'h123450B7, Imm_U,    32'h12345000, 1'b0};
    tbl[4] = '{"jal",   32'h0080006F, Imm_J,    32'h00000008, 1'b0};
    tbl[5] = '{"ill7f", 32'h0000007F, Imm_None, 32'h00000000, 1'b1};
    tbl[6] = '{"opp",   32'h00000077, Imm_None, 32'h00000000, 1'b0};
    tbl[7] = '{"add",   32'h002081B3, Imm_None, 32'h00000000, 1'b0};
    tbl[8] = '{"lw",    32'h00812083, Imm_I,    32'h00000008, 1'b0};
    tbl[9] = '{"auipc", 32'h00001097, Imm_U,    32'h00001000, 1'b0};

    bus.if_valid = 1'b0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_if_ready", 32'(bus.if_ready), 32'd1);
    chk("rst_id_imm",   bus.id_imm, 32'd0);
    chk("rst_id_sel",   32'(bus.id_imm_sel), 32'(Imm_None));

    // Back-to-back stream with execute always ready: one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      bus.if_valid = 1'b1;
      bus.if_inst  = tbl[i].inst;
      bus.if_pc    = 32'h1000 + 32'(4 * i);
      step();
      chk({tbl[i].name, "_valid"}, 32'(bus.id_valid), 32'd1);
      chk({tbl[i].name, "_ready"}, 32'(bus.if_ready), 32'd1);
      chk({tbl[i].name, "_inst"},  bus.id_inst, tbl[i].inst);
      chk({tbl[i].name, "_pc"},    bus.id_pc, 32'h1000 + 32'(4 * i));
      chk({tbl[i].name, "_sel"},   32'(bus.id_imm_sel), 32'(tbl[i].sel));
      chk({tbl[i].name, "_imm"},   bus.id_imm, tbl[i].imm);
      chk({tbl[i].name, "_ill"},   32'(bus.id_illegal), 32'(tbl[i].ill));
    end
    bus.if_valid = 1'b0;
    step();
    chk("drain_id_valid", 32'(bus.id_valid), 32'd0);

    // Back-pressure: 4 beats, execute stalled for the first 3 cycles.
    idx = 0;
    oidx = 0;
    for (int c = 0; c < 20 && oidx < 4; c++) begin
      bus.if_valid = (idx < 4);
      bus.if_inst  = 32'h00000013;
      bus.if_pc    = 32'h200 + 32'(4 * idx);
      bus.id_ready = (c >= 3);
      if (c == 2) chk("bp_if_ready_low", 32'(bus.if_ready), 32'd0);
      if (c == 1 || c == 2) chk("bp_hold_pc", bus.id_pc, 32'h200);
      acc  = bus.if_valid && bus.if_ready;
      outx = bus.id_valid && bus.id_ready;
      if (outx) begin
        chk("bp_order_pc", bus.id_pc, 32'h200 + 32'(4 * oidx));
        oidx++;
      end
      step();
      if (acc) idx++;
    end
    bus.if_valid = 1'b0;
    chk("bp_all_accepted", 32'(idx), 32'd4);
    chk("bp_all_delivered", 32'(oidx), 32'd4);
    step();
    chk("bp_empty_after", 32'(bus.id_valid), 32'd0);

    // Flush while full with a beat on offer.
    bus.id_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h300;
    step();
    bus.if_pc    = 32'h304;
    step();
    chk("fl_two_ready", 32'(bus.if_ready), 32'd0);
    bus.if_pc = 32'h308;
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    chk("fl_id_valid", 32'(bus.id_valid), 32'd0);
    chk("fl_if_ready", 32'(bus.if_ready), 32'd1);
    bus.id_ready = 1'b1;
    step();
    step();
    chk("fl_no_ghost", 32'(bus.id_valid), 32'd0);

    // Flush from EMPTY drops an offered beat even though if_ready = 1.
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h30C;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    chk("fl_empty_drop", 32'(bus.id_valid), 32'd0);

    // Reset while holding one beat.
    bus.id_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_inst  = 32'hFFF00093;
    bus.if_pc    = 32'h400;
    step();
    bus.if_valid = 1'b0;
    chk("rs_one_valid", 32'(bus.id_valid), 32'd1);
    chk("rs_one_imm", bus.id_imm, 32'hFFFFFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rs_if_ready", 32'(bus.if_ready), 32'd1);
    chk("rs_id_imm", bus.id_imm, 32'd0);
    chk("rs_id_pc", bus.id_pc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
